// File: rtl/bus_load_demux_if.sv
// Bus-side load handshake: word, destination code, valid/ready.
// The master drives the bus word; this block is the slave.
interface bus_load_demux_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] bus_contents;
   logic [4:0]        load_sel;
   logic              load_valid;
   logic              load_ready;

   modport master (
      output bus_contents,
      output load_sel,
      output load_valid,
      input  load_ready
   );

   modport slave (
      input  bus_contents,
      input  load_sel,
      input  load_valid,
      output load_ready
   );
endinterface

// File: rtl/bus_load_demux.sv
// Bus write endpoint: capture stage, then commit into a 32-entry bank.
// Registered read port bypasses a same-edge commit.
module bus_load_demux #(
   parameter int          DATA_W        = 32,
   parameter logic [31:0] RESERVED_MASK = 32'hFD10_0000,
   parameter int          CNT_W         = 16
) (
   input  logic                  clk,
   input  logic                  clr,
   bus_load_demux_if.slave       bus,
   input  logic                  hold,
   input  logic [4:0]            rd_sel,
   output logic [DATA_W-1:0]     rd_data,
   output logic [31:0]           load_en,
   output logic                  bad_dest,
   output logic [CNT_W-1:0]      write_count
);

   logic              s1_valid_q, s1_valid_d;
   logic [DATA_W-1:0] s1_data_q, s1_data_d;
   logic [4:0]        s1_sel_q, s1_sel_d;
   logic [DATA_W-1:0] bank_q [32];
   logic [DATA_W-1:0] bank_d [32];
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic [31:0]       load_en_q, load_en_d;
   logic              bad_q, bad_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic accept, commit, good;

   assign bus.load_ready = !(s1_valid_q && hold);
   assign accept = bus.load_valid && bus.load_ready;
   assign commit = s1_valid_q && !hold;
   assign good   = commit && !RESERVED_MASK[s1_sel_q];

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_sel_d   = s1_sel_q;
      bank_d     = bank_q;
      load_en_d  = '0;
      bad_d      = bad_q;
      cnt_d      = cnt_q;
      if (commit) s1_valid_d = 1'b0;
      if (accept) begin
         s1_valid_d = 1'b1;
         s1_data_d  = bus.bus_contents;
         s1_sel_d   = bus.load_sel;
      end
      if (good) begin
         bank_d[s1_sel_q] = s1_data_q;
         load_en_d = 32'd1 << s1_sel_q;
         if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end else if (commit) begin
         bad_d = 1'b1;
      end
      // Bypass so a read of the destination sees the word being committed
      if (RESERVED_MASK[rd_sel])
         rd_data_d = '0;
      else if (good && s1_sel_q == rd_sel)
         rd_data_d = s1_data_q;
      else
         rd_data_d = bank_q[rd_sel];
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_sel_q   <= '0;
         for (int i = 0; i < 32; i++) bank_q[i] <= '0;
         rd_data_q  <= '0;
         load_en_q  <= '0;
         bad_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s1_sel_q   <= s1_sel_d;
         bank_q     <= bank_d;
         rd_data_q  <= rd_data_d;
         load_en_q  <= load_en_d;
         bad_q      <= bad_d;
         cnt_q      <= cnt_d;
      end
   end

   assign rd_data     = rd_data_q;
   assign load_en     = load_en_q;
   assign bad_dest    = bad_q;
   assign write_count = cnt_q;

endmodule
